// File: rtl/scalar_regfile_mw.sv
// Multi-warp scalar register file: two read ports with writeback bypass,
// per-register busy scoreboard and a per-warp execution-mask stack on register 1.
module scalar_regfile_mw #(
  parameter int NUM_WARPS     = 4,
  parameter int REGS_PER_WARP = 32,
  parameter int DATA_W        = 32,
  parameter int MASK_DEPTH    = 4,
  localparam int WID_W   = $clog2(NUM_WARPS),
  localparam int RA_W    = $clog2(REGS_PER_WARP),
  localparam int DEPTH_W = $clog2(MASK_DEPTH + 1),
  localparam int SP_W    = (MASK_DEPTH > 1) ? $clog2(MASK_DEPTH) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        rd_valid,
  output logic                        rd_ready,
  input  logic [WID_W-1:0]            rd_warp,
  input  logic [RA_W-1:0]             rs1_addr,
  input  logic [RA_W-1:0]             rs2_addr,
  input  logic [RA_W-1:0]             rd_addr,
  input  logic                        rd_reserve,
  output logic                        rs_valid,
  output logic [WID_W-1:0]            rs_warp,
  output logic [DATA_W-1:0]           rs1,
  output logic [DATA_W-1:0]           rs2,
  input  logic                        wb_valid,
  input  logic [WID_W-1:0]            wb_warp,
  input  logic [RA_W-1:0]             wb_addr,
  input  logic [1:0]                  wb_sel,
  input  logic [DATA_W-1:0]           alu_out,
  input  logic [DATA_W-1:0]           lsu_out,
  input  logic [DATA_W-1:0]           next_pc,
  input  logic [DATA_W-1:0]           v_to_s_value,
  input  logic                        mask_push,
  input  logic                        mask_pop,
  input  logic [WID_W-1:0]            mask_warp,
  input  logic [DATA_W-1:0]           mask_new,
  output logic [NUM_WARPS*DATA_W-1:0] exec_mask,
  output logic                        stack_err
);

  logic [DATA_W-1:0]        regs      [NUM_WARPS][REGS_PER_WARP];
  logic [DATA_W-1:0]        stack     [NUM_WARPS][MASK_DEPTH];
  logic [DEPTH_W-1:0]       depth     [NUM_WARPS];
  logic [REGS_PER_WARP-1:0] busy      [NUM_WARPS];
  logic [REGS_PER_WARP-1:0] busy_clr  [NUM_WARPS];
  logic [REGS_PER_WARP-1:0] busy_next [NUM_WARPS];

  logic [DATA_W-1:0]  wb_data;
  logic [DEPTH_W-1:0] cur_depth;
  logic [DEPTH_W-1:0] top_idx;
  logic               push_ok, pop_ok, stack_fault;
  logic               wb_clr, wb_en, rd_fire;
  logic [DATA_W-1:0]  rs1_next, rs2_next;

  always_comb begin
    case (wb_sel)
      2'd0:    wb_data = alu_out;
      2'd1:    wb_data = lsu_out;
      2'd2:    wb_data = next_pc;
      default: wb_data = v_to_s_value;
    endcase
  end

  // A simultaneous push and pop cancels out; only a lone push/pop can fault.
  assign cur_depth   = depth[mask_warp];
  assign top_idx     = cur_depth - 1'b1;
  assign push_ok     = mask_push && !mask_pop && (cur_depth < DEPTH_W'(MASK_DEPTH));
  assign pop_ok      = mask_pop && !mask_push && (cur_depth != '0);
  assign stack_fault = (mask_push && !mask_pop && !push_ok) ||
                       (mask_pop && !mask_push && !pop_ok);

  assign wb_clr = wb_valid && (wb_addr != '0);
  assign wb_en  = wb_clr && !((push_ok || pop_ok) && (mask_warp == wb_warp) &&
                              (wb_addr == RA_W'(1)));

  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) busy_clr[w] = busy[w];
    if (wb_clr) busy_clr[wb_warp][wb_addr] = 1'b0;
  end

  assign rd_ready = !busy_clr[rd_warp][rs1_addr] && !busy_clr[rd_warp][rs2_addr] &&
                    !(rd_reserve && busy_clr[rd_warp][rd_addr]);
  assign rd_fire  = rd_valid && rd_ready;

  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) busy_next[w] = busy_clr[w];
    if (rd_fire && rd_reserve && (rd_addr != '0)) busy_next[rd_warp][rd_addr] = 1'b1;
  end

  assign rs1_next = (wb_en && (wb_warp == rd_warp) && (wb_addr == rs1_addr)) ?
                    wb_data : regs[rd_warp][rs1_addr];
  assign rs2_next = (wb_en && (wb_warp == rd_warp) && (wb_addr == rs2_addr)) ?
                    wb_data : regs[rd_warp][rs2_addr];

  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) exec_mask[w*DATA_W +: DATA_W] = regs[w][1];
  end

  // Register 0 is never written, so it keeps its reset value of zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        for (int r = 0; r < REGS_PER_WARP; r++) regs[w][r] <= (r == 1) ? '1 : '0;
        for (int s = 0; s < MASK_DEPTH; s++) stack[w][s] <= '0;
        depth[w] <= '0;
        busy[w]  <= '0;
      end
      stack_err <= 1'b0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) busy[w] <= busy_next[w];
      if (wb_en) regs[wb_warp][wb_addr] <= wb_data;
      if (push_ok) begin
        stack[mask_warp][cur_depth[SP_W-1:0]] <= regs[mask_warp][1];
        regs[mask_warp][1] <= mask_new;
        depth[mask_warp]   <= cur_depth + 1'b1;
      end
      if (pop_ok) begin
        regs[mask_warp][1] <= stack[mask_warp][top_idx[SP_W-1:0]];
        depth[mask_warp]   <= top_idx;
      end
      if (stack_fault) stack_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rs_valid <= 1'b0;
      rs_warp  <= '0;
      rs1      <= '0;
      rs2      <= '0;
    end else begin
      rs_valid <= rd_fire;
      if (rd_fire) begin
        rs_warp <= rd_warp;
        rs1     <= rs1_next;
        rs2     <= rs2_next;
      end
    end
  end

endmodule

// File: tb/tb_scalar_regfile_mw.sv
// Self-checking bench for scalar_regfile_mw: directed scenarios plus random
// traffic compared against a behavioural array/stack model.
module tb_scalar_regfile_mw;
  localparam int NW = 4;
  localparam int NR = 32;
  localparam int DW = 32;
  localparam int MD = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          rd_valid, rd_ready, rd_reserve, rs_valid;
  logic [1:0]    rd_warp, rs_warp, wb_warp, mask_warp, wb_sel;
  logic [4:0]    rs1_addr, rs2_addr, rd_addr, wb_addr;
  logic [DW-1:0] rs1, rs2, alu_out, lsu_out, next_pc, v_to_s_value, mask_new;
  logic          wb_valid, mask_push, mask_pop, stack_err;
  logic [NW*DW-1:0] exec_mask;

  scalar_regfile_mw dut (
    .clk(clk), .reset(reset),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_warp(rd_warp),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr), .rd_reserve(rd_reserve),
    .rs_valid(rs_valid), .rs_warp(rs_warp), .rs1(rs1), .rs2(rs2),
    .wb_valid(wb_valid), .wb_warp(wb_warp), .wb_addr(wb_addr), .wb_sel(wb_sel),
    .alu_out(alu_out), .lsu_out(lsu_out), .next_pc(next_pc), .v_to_s_value(v_to_s_value),
    .mask_push(mask_push), .mask_pop(mask_pop), .mask_warp(mask_warp), .mask_new(mask_new),
    .exec_mask(exec_mask), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] m_regs [NW][NR];
  bit            m_busy [NW][NR];
  logic [DW-1:0] m_stk  [NW][MD];
  int            m_depth[NW];
  bit            m_err;
  bit            exp_rs_valid;
  logic [DW-1:0] exp_rs1, exp_rs2;
  logic [1:0]    exp_rs_warp;

  function automatic void model_reset();
    for (int w = 0; w < NW; w++) begin
      for (int r = 0; r < NR; r++) begin
        m_regs[w][r] = (r == 1) ? 32'hFFFF_FFFF : 32'h0;
        m_busy[w][r] = 0;
      end
      m_depth[w] = 0;
    end
    m_err = 0;
    exp_rs_valid = 0;
  endfunction

  function automatic bit busy_after_wb(int w, int a);
    if (wb_valid && wb_addr != 0 && int'(wb_warp) == w && int'(wb_addr) == a) return 0;
    return m_busy[w][a];
  endfunction

  function automatic bit model_ready();
    int w = int'(rd_warp);
    return !busy_after_wb(w, int'(rs1_addr)) && !busy_after_wb(w, int'(rs2_addr)) &&
           !(rd_reserve && busy_after_wb(w, int'(rd_addr)));
  endfunction

  function automatic logic [DW-1:0] model_mask(int w);
    return m_regs[w][1];
  endfunction

  // Advance the model by one clock using the current input values.
  function automatic void model_update();
    logic [DW-1:0] wd;
    bit push_ok, pop_ok, wb_write, fire;
    int mw = int'(mask_warp);
    case (wb_sel)
      2'd0: wd = alu_out;
      2'd1: wd = lsu_out;
      2'd2: wd = next_pc;
      default: wd = v_to_s_value;
    endcase
    push_ok = mask_push && !mask_pop && m_depth[mw] < MD;
    pop_ok  = mask_pop && !mask_push && m_depth[mw] > 0;
    if ((mask_push != mask_pop) && !push_ok && !pop_ok) m_err = 1;
    wb_write = wb_valid && wb_addr != 0 &&
               !((push_ok || pop_ok) && mask_warp == wb_warp && wb_addr == 1);
    fire = rd_valid && model_ready();
    exp_rs_valid = fire;
    if (fire) begin
      exp_rs_warp = rd_warp;
      exp_rs1 = (wb_write && wb_warp == rd_warp && wb_addr == rs1_addr) ? wd : m_regs[rd_warp][rs1_addr];
      exp_rs2 = (wb_write && wb_warp == rd_warp && wb_addr == rs2_addr) ? wd : m_regs[rd_warp][rs2_addr];
    end
    if (wb_valid && wb_addr != 0) m_busy[wb_warp][wb_addr] = 0;
    if (fire && rd_reserve && rd_addr != 0) m_busy[rd_warp][rd_addr] = 1;
    if (wb_write) m_regs[wb_warp][wb_addr] = wd;
    if (push_ok) begin
      m_stk[mw][m_depth[mw]] = m_regs[mw][1];
      m_regs[mw][1] = mask_new;
      m_depth[mw]++;
    end
    if (pop_ok) begin
      m_depth[mw]--;
      m_regs[mw][1] = m_stk[mw][m_depth[mw]];
    end
  endfunction

  task automatic idle();
    rd_valid = 0; rd_warp = 0; rs1_addr = 0; rs2_addr = 0; rd_addr = 0; rd_reserve = 0;
    wb_valid = 0; wb_warp = 0; wb_addr = 0; wb_sel = 0;
    alu_out = 0; lsu_out = 0; next_pc = 0; v_to_s_value = 0;
    mask_push = 0; mask_pop = 0; mask_warp = 0; mask_new = 0;
  endtask

  task automatic step();
    #1;
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    idle();
    reset = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (rs_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rs_valid got %b want 0", rs_valid); end
    n_checks++;
    if (stack_err !== 1'b0) begin n_errors++; $display("FAIL reset_stack_err got %b want 0", stack_err); end
    n_checks++;
    if (exec_mask !== {NW*DW{1'b1}}) begin n_errors++; $display("FAIL reset_exec_mask got %h want all ones", exec_mask); end
    rd_valid = 1; rd_warp = 2; rs1_addr = 0; rs2_addr = 1;
    #1;
    n_checks++;
    if (rd_ready !== 1'b1) begin n_errors++; $display("FAIL reset_rd_ready got %b want 1", rd_ready); end
    step();
    idle();
    n_checks++;
    if (rs_valid !== 1'b1 || rs_warp !== 2'd2 || rs1 !== 32'h0 || rs2 !== 32'hFFFF_FFFF) begin
      n_errors++;
      $display("FAIL read_r0_r1 got v=%b w=%0d rs1=%h rs2=%h want v=1 w=2 rs1=0 rs2=ffffffff", rs_valid, rs_warp, rs1, rs2);
    end
    step();
    n_checks++;
    if (rs_valid !== 1'b0) begin n_errors++; $display("FAIL rs_valid_pulse got %b want 0", rs_valid); end
  endtask

  task automatic test_bypass();
    idle();
    wb_valid = 1; wb_warp = 0; wb_addr = 5; wb_sel = 2; next_pc = 32'h40; alu_out = 32'hDEAD;
    rd_valid = 1; rd_warp = 0; rs1_addr = 5; rs2_addr = 0;
    step();
    n_checks++;
    if (rs_valid !== 1'b1 || rs1 !== 32'h40 || rs2 !== 32'h0) begin
      n_errors++; $display("FAIL bypass got v=%b rs1=%h rs2=%h want v=1 rs1=40 rs2=0", rs_valid, rs1, rs2);
    end
    idle();
    wb_valid = 1; wb_warp = 0; wb_addr = 0; wb_sel = 0; alu_out = 32'h1234_5678;
    rd_valid = 1; rd_warp = 0; rs1_addr = 0; rs2_addr = 5;
    step();
    n_checks++;
    if (rs1 !== 32'h0 || rs2 !== 32'h40) begin
      n_errors++; $display("FAIL r0_write_dropped got rs1=%h rs2=%h want rs1=0 rs2=40", rs1, rs2);
    end
  endtask

  task automatic test_busy();
    idle();
    rd_valid = 1; rd_warp = 1; rs1_addr = 2; rs2_addr = 3; rd_addr = 7; rd_reserve = 1;
    step();
    n_checks++;
    if (rs_valid !== 1'b1) begin n_errors++; $display("FAIL reserve_accept got %b want 1", rs_valid); end
    rd_reserve = 0; rs1_addr = 7;
    #1;
    n_checks++;
    if (rd_ready !== 1'b0) begin n_errors++; $display("FAIL busy_blocks got %b want 0", rd_ready); end
    step();
    step();
    n_checks++;
    if (rs_valid !== 1'b0) begin n_errors++; $display("FAIL busy_no_issue got %b want 0", rs_valid); end
    wb_valid = 1; wb_warp = 1; wb_addr = 7; wb_sel = 0; alu_out = 32'h1234;
    #1;
    n_checks++;
    if (rd_ready !== 1'b1) begin n_errors++; $display("FAIL wb_clear_ready got %b want 1", rd_ready); end
    step();
    n_checks++;
    if (rs_valid !== 1'b1 || rs1 !== 32'h1234) begin
      n_errors++; $display("FAIL busy_release got v=%b rs1=%h want v=1 rs1=1234", rs_valid, rs1);
    end
    idle();
    rd_valid = 1; rd_warp = 1; rd_addr = 9; rd_reserve = 1;
    wb_valid = 1; wb_warp = 1; wb_addr = 9; wb_sel = 1; lsu_out = 32'h55;
    step();
    idle();
    rd_valid = 1; rd_warp = 1; rs1_addr = 9;
    #1;
    n_checks++;
    if (rd_ready !== 1'b0) begin n_errors++; $display("FAIL reserve_wins got %b want 0", rd_ready); end
    wb_valid = 1; wb_warp = 1; wb_addr = 9; wb_sel = 3; v_to_s_value = 32'hABCD;
    step();
    n_checks++;
    if (rs_valid !== 1'b1 || rs1 !== 32'hABCD) begin
      n_errors++; $display("FAIL reserve_wins_clear got v=%b rs1=%h want v=1 rs1=abcd", rs_valid, rs1);
    end
    idle();
  endtask

  task automatic test_mask_stack();
    idle();
    mask_warp = 3; mask_push = 1; mask_new = 32'h0F;
    step();
    mask_new = 32'h03;
    step();
    n_checks++;
    if (exec_mask[3*DW +: DW] !== 32'h03) begin n_errors++; $display("FAIL push_two got %h want 3", exec_mask[3*DW +: DW]); end
    mask_push = 0; mask_pop = 1;
    step();
    n_checks++;
    if (exec_mask[3*DW +: DW] !== 32'h0F) begin n_errors++; $display("FAIL pop_one got %h want f", exec_mask[3*DW +: DW]); end
    step();
    n_checks++;
    if (exec_mask[3*DW +: DW] !== 32'hFFFF_FFFF || stack_err !== 1'b0) begin
      n_errors++; $display("FAIL pop_two got %h err=%b want ffffffff err=0", exec_mask[3*DW +: DW], stack_err);
    end
    step();
    n_checks++;
    if (exec_mask[3*DW +: DW] !== 32'hFFFF_FFFF || stack_err !== 1'b1) begin
      n_errors++; $display("FAIL underflow got %h err=%b want ffffffff err=1", exec_mask[3*DW +: DW], stack_err);
    end
    idle();
  endtask

  task automatic test_overflow();
    apply_reset();
    mask_warp = 0; mask_push = 1;
    for (int i = 0; i < MD; i++) begin
      mask_new = 32'h100 + i;
      step();
    end
    n_checks++;
    if (stack_err !== 1'b0 || exec_mask[0 +: DW] !== 32'h100 + MD - 1) begin
      n_errors++; $display("FAIL fill got %h err=%b want %h err=0", exec_mask[0 +: DW], stack_err, 32'h100 + MD - 1);
    end
    mask_new = 32'hBAD;
    step();
    n_checks++;
    if (stack_err !== 1'b1 || exec_mask[0 +: DW] !== 32'h100 + MD - 1) begin
      n_errors++; $display("FAIL overflow got %h err=%b want %h err=1", exec_mask[0 +: DW], stack_err, 32'h100 + MD - 1);
    end
    n_checks++;
    if (exec_mask[NW*DW-1:DW] !== {(NW-1)*DW{1'b1}}) begin
      n_errors++; $display("FAIL other_warps got %h want all ones", exec_mask[NW*DW-1:DW]);
    end
    mask_push = 1; mask_pop = 1; mask_warp = 2; mask_new = 32'h77;
    step();
    n_checks++;
    if (exec_mask[2*DW +: DW] !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL push_pop_noop got %h want ffffffff", exec_mask[2*DW +: DW]); end
    idle();
    mask_push = 1; mask_warp = 1; mask_new = 32'h5A;
    wb_valid = 1; wb_warp = 1; wb_addr = 1; wb_sel = 0; alu_out = 32'h99;
    step();
    n_checks++;
    if (exec_mask[1*DW +: DW] !== 32'h5A) begin n_errors++; $display("FAIL mask_beats_wb got %h want 5a", exec_mask[1*DW +: DW]); end
    idle();
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      rd_valid = ($urandom_range(0, 3) != 0);
      rd_warp = 2'($urandom_range(0, NW - 1));
      rs1_addr = 5'($urandom_range(0, 7));
      rs2_addr = 5'($urandom_range(0, 7));
      rd_addr = 5'($urandom_range(0, 7));
      rd_reserve = $urandom_range(0, 1) == 1;
      wb_valid = $urandom_range(0, 1) == 1;
      wb_warp = 2'($urandom_range(0, NW - 1));
      wb_addr = 5'($urandom_range(0, 7));
      wb_sel = 2'($urandom_range(0, 3));
      alu_out = $urandom; lsu_out = $urandom; next_pc = $urandom; v_to_s_value = $urandom;
      mask_push = ($urandom_range(0, 5) == 0);
      mask_pop = ($urandom_range(0, 5) == 0);
      mask_warp = 2'($urandom_range(0, NW - 1));
      mask_new = $urandom;
      #1;
      n_checks++;
      if (rd_ready !== model_ready()) begin
        n_errors++; $display("FAIL rand_ready cycle %0d got %b want %b", i, rd_ready, model_ready());
      end
      step();
      n_checks++;
      if (rs_valid !== exp_rs_valid || (exp_rs_valid &&
          (rs1 !== exp_rs1 || rs2 !== exp_rs2 || rs_warp !== exp_rs_warp))) begin
        n_errors++;
        $display("FAIL rand_read cycle %0d got v=%b w=%0d %h %h want v=%b w=%0d %h %h", i, rs_valid, rs_warp,
                 rs1, rs2, exp_rs_valid, exp_rs_warp, exp_rs1, exp_rs2);
      end
      for (int w = 0; w < NW; w++) begin
        n_checks++;
        if (exec_mask[w*DW +: DW] !== model_mask(w)) begin
          n_errors++; $display("FAIL rand_mask cycle %0d warp %0d got %h want %h", i, w, exec_mask[w*DW +: DW], model_mask(w));
        end
      end
      n_checks++;
      if (stack_err !== m_err) begin n_errors++; $display("FAIL rand_err cycle %0d got %b want %b", i, stack_err, m_err); end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    idle();
    wb_valid = 1; wb_warp = 2; wb_addr = 6; alu_out = 32'hCAFE;
    mask_push = 1; mask_warp = 2; mask_new = 32'hAA;
    step();
    idle();
    rd_valid = 1; rd_warp = 2; rd_addr = 4; rd_reserve = 1;
    step();
    idle();
    rd_valid = 1; rd_warp = 2; rs1_addr = 4; rs2_addr = 6;
    reset = 0;
    model_reset();
    #1;
    n_checks++;
    if (rs_valid !== 1'b0 || stack_err !== 1'b0 || exec_mask !== {NW*DW{1'b1}}) begin
      n_errors++; $display("FAIL async_reset got v=%b err=%b mask=%h want 0 0 all ones", rs_valid, stack_err, exec_mask);
    end
    n_checks++;
    if (rd_ready !== 1'b1) begin n_errors++; $display("FAIL reset_busy_clear got %b want 1", rd_ready); end
    @(posedge clk);
    idle();
    @(negedge clk) reset = 1;
    @(posedge clk);
    #1;
    n_checks++;
    if (rs_valid !== 1'b0) begin n_errors++; $display("FAIL post_release_valid got %b want 0", rs_valid); end
    rd_valid = 1; rd_warp = 2; rs1_addr = 6; rs2_addr = 4;
    mask_pop = 1; mask_warp = 2;
    step();
    n_checks++;
    if (rs_valid !== 1'b1 || rs1 !== 32'h0 || stack_err !== 1'b1 || exec_mask[2*DW +: DW] !== 32'hFFFF_FFFF) begin
      n_errors++; $display("FAIL post_reset_state got v=%b rs1=%h err=%b mask=%h want 1 0 1 ffffffff",
                           rs_valid, rs1, stack_err, exec_mask[2*DW +: DW]);
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_bypass();
    test_busy();
    test_mask_stack();
    test_overflow();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/scalar_regfile_mw.md
SCALAR_REGFILE_MW -- requirements
Module: scalar_regfile_mw

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 4, number of warps sharing the file.
REQ-002 SHALL have parameter REGS_PER_WARP, default 32, scalar registers per warp (power of 2).
REQ-003 SHALL have parameter DATA_W, default 32, register width.
REQ-004 SHALL have parameter MASK_DEPTH, default 4, per-warp execution-mask stack depth.
REQ-005 SHALL use localparams WID_W=$clog2(NUM_WARPS), RA_W=$clog2(REGS_PER_WARP).
REQ-006 SHALL have one clock and an asynchronous active-low reset, named clk and reset.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 reset  in  1  async active-low reset.
REQ-009 rd_valid  in  1  read request; rd_ready  out  1  request accepted.
REQ-010 rd_warp  in  WID_W; rs1_addr, rs2_addr, rd_addr  in  RA_W each.
REQ-011 rd_reserve  in  1  mark rd_addr busy when request accepted.
REQ-012 rs_valid  out  1; rs_warp  out  WID_W; rs1, rs2  out  DATA_W  registered operands.
REQ-013 wb_valid  in  1; wb_warp  in  WID_W; wb_addr  in  RA_W; wb_sel  in  2  (0 alu, 1 lsu, 2 next_pc, 3 v_to_s).
REQ-014 alu_out, lsu_out, next_pc, v_to_s_value  in  DATA_W each.
REQ-015 mask_push, mask_pop  in  1; mask_warp  in  WID_W; mask_new  in  DATA_W.
REQ-016 exec_mask  out  NUM_WARPS*DATA_W  register 1 of each warp, warp w at bits [w*DATA_W +: DATA_W].
REQ-017 stack_err  out  1  sticky overflow/underflow flag.

Function
REQ-018 Register 0 of every warp SHALL read 0; writes to it SHALL be dropped without clearing busy state errors.
REQ-019 Register 1 of every warp SHALL be the execution mask.
REQ-020 rd_ready SHALL be combinational: low when busy[rd_warp][rs1_addr], busy[rd_warp][rs2_addr], or (rd_reserve and busy[rd_warp][rd_addr]) is set after same-cycle writeback clear; high otherwise.
REQ-021 On rd_valid&&rd_ready, rs1/rs2/rs_warp SHALL load next edge and rs_valid SHALL pulse high exactly one cycle; latency 1.
REQ-022 Same-cycle writeback to a read address of the same warp SHALL bypass: rs1/rs2 get the new value.
REQ-023 Accepted rd_reserve with rd_addr!=0 SHALL set busy[rd_warp][rd_addr] next edge.
REQ-024 wb_valid SHALL write selected source to [wb_warp][wb_addr] (addr!=0) and clear its busy bit next edge.
REQ-025 Reserve and writeback of the same entry in one cycle: writeback clears, reserve then wins (bit ends set).
REQ-026 mask_push (depth<MASK_DEPTH): push current register 1 of mask_warp, load mask_new into register 1.
REQ-027 mask_pop (depth>0): restore register 1 from stack top, decrement depth.
REQ-028 Push when full or pop when empty SHALL be ignored and set stack_err until reset.
REQ-029 mask_push and mask_pop together: no-op, stack_err unchanged.
REQ-030 Mask operation and wb to register 1 of the same warp in one cycle: mask operation wins.
REQ-031 Busy bits SHALL not affect mask operations.

Reset
REQ-032 On reset low, asynchronously: all registers 0, every register 1 all-ones, busy bits 0, stack depths 0, rs_valid 0, rs1/rs2/rs_warp 0, stack_err 0.
REQ-033 Reset asserted mid-operation SHALL discard any in-flight request; rs_valid SHALL be low the first cycle after release.

Verification
REQ-034 After reset, read warp 2 r0,r1 -> rs1=0, rs2=0xFFFFFFFF, rs_valid one cycle later.
REQ-035 wb warp 0 r5 sel=2 next_pc=0x40 with same-cycle read r5 -> rs1=0x40 (bypass).
REQ-036 Read warp 1 rd=7 reserve; next read rs1=7 -> rd_ready=0 until wb r7, then accepted.
REQ-037 Push 0x0F, 0x03 on warp 3 -> exec_mask[3]=0x03; pop twice -> 0x0F, then 0xFFFFFFFF; third pop -> stack_err=1, mask unchanged.
REQ-038 Push MASK_DEPTH+1 times on warp 0 -> last push ignored, stack_err=1, other warps unaffected.
REQ-039 Assert reset with busy bits and stack entries live -> all state at reset values, rs_valid=0.
